// File: rtl/mem_copy_engine.sv
// mem_copy_engine: byte block copier over the data memory port with a modulo checksum
module mem_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_w,
    output logic              mem_r,
    input  logic [DATA_W-1:0] mem_dataout
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t            r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_buf;
    logic [DATA_W-1:0] r_sum;
    logic [ADDR_W-1:0] w_idx_nxt;
    assign w_idx_nxt  = r_idx + 1'b1;
    assign busy       = (r_state == READ) || (r_state == WRITE);
    assign done       = r_state == DONE;
    assign mem_r      = r_state == READ;
    assign mem_w      = (r_state == WRITE) && !rst;
    assign mem_adr    = (r_state == READ) ? r_src + r_idx : (r_state == WRITE) ? r_dst + r_idx : '0;
    assign mem_datain = (r_state == WRITE) ? r_buf : '0;
    assign checksum   = r_sum;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_buf   <= '0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_src   <= src_base;
                    r_dst   <= dst_base;
                    r_len   <= length;
                    r_idx   <= '0;
                    r_sum   <= '0;
                    r_state <= (length != '0) ? READ : DONE;
                end
                READ: begin
                    r_buf   <= mem_dataout;
                    r_sum   <= r_sum + mem_dataout;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_idx   <= w_idx_nxt;
                    r_state <= (w_idx_nxt == r_len) ? DONE : READ;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: table-driven copies with a bus-transaction scoreboard and memory model
module tb_mem_copy_engine;
    logic       clk = 1'b0;
    logic       rst, start, busy, done, mem_w, mem_r, load;
    logic [7:0] src_base, dst_base, length, checksum, mem_adr, mem_datain, mem_dataout;
    logic [7:0] mem [256];
    logic [7:0] refm [256];
    logic [7:0] scr [256];
    typedef struct packed {logic w; logic [7:0] a; logic [7:0] d;} op_t;
    typedef struct {logic [7:0] s; logic [7:0] d; logic [7:0] l; logic [7:0] sum; int inj; int rsta;} vec_t;
    op_t q[$];
    vec_t vecs[6];
    int tests = 0;
    int fails = 0;

    mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
        .length(length), .busy(busy), .done(done), .checksum(checksum), .mem_adr(mem_adr),
        .mem_datain(mem_datain), .mem_w(mem_w), .mem_r(mem_r), .mem_dataout(mem_dataout)
    );

    always #5 clk = ~clk;
    assign mem_dataout = mem[mem_adr];
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else if (mem_w) begin
            mem[mem_adr] <= mem_datain;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 256; i++) refm[i] = 8'(i);
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    task automatic run(input string nm, input vec_t v);
        int dn = 0;
        int dc = -1;
        int mism = 0;
        logic [7:0] a;
        logic [7:0] b;
        op_t e;
        q.delete();
        for (int i = 0; i < 256; i++) scr[i] = refm[i];
        for (int k = 0; k < int'(v.l); k++) begin
            a = 8'(v.s + k);
            b = 8'(v.d + k);
            q.push_back({1'b0, a, scr[a]});
            scr[b] = scr[a];
            q.push_back({1'b1, b, scr[a]});
        end
        @(negedge clk);
        start = 1'b1; src_base = v.s; dst_base = v.d; length = v.l;
        @(negedge clk);
        start = 1'b0; src_base = 8'hAA; dst_base = 8'h55; length = 8'h03;
        for (int c = 0; c < 2 * int'(v.l) + 4; c++) begin
            if (c != v.rsta) begin
                if (mem_r && mem_w) chk({nm, " r_and_w"}, 1, 0);
                if (mem_r || mem_w) begin
                    if (q.size() == 0) chk({nm, " unexpected_op"}, {mem_w, mem_adr}, 0);
                    else begin
                        e = q.pop_front();
                        chk({nm, " bus_op"}, {mem_w, mem_adr, mem_w ? mem_datain : mem_dataout}, e);
                        if (e.w) refm[e.a] = e.d;
                    end
                end else chk({nm, " idle_bus"}, {mem_adr, mem_datain}, 0);
                if (done) begin
                    dn++;
                    if (dc < 0) dc = c;
                    chk({nm, " busy_in_done"}, busy, 0);
                    chk({nm, " checksum"}, checksum, v.sum);
                end
            end
            start = (c == v.inj);
            if (c == v.inj) begin
                src_base = 8'h00; dst_base = 8'h40; length = 8'h07;
            end
            if (c == v.rsta) rst = 1'b1;
            @(negedge clk);
            if (c == v.rsta) begin
                chk({nm, " rst_outputs"}, {busy, done, mem_w, mem_r, checksum}, 0);
                rst = 1'b0;
                q.delete();
                break;
            end
        end
        start = 1'b0;
        chk({nm, " done_count"}, dn, (v.rsta < 0) ? 1 : 0);
        if (v.rsta < 0) begin
            chk({nm, " done_cycle"}, dc, 2 * int'(v.l));
            chk({nm, " ops_left"}, q.size(), 0);
        end
        for (int i = 0; i < 256; i++) if (mem[i] !== refm[i]) mism++;
        chk({nm, " mem_contents"}, mism, 0);
    endtask

    initial begin
        vecs[0] = '{s: 8'h10, d: 8'h80, l: 8'd4, sum: 8'h46, inj: -1, rsta: -1};
        vecs[1] = '{s: 8'h00, d: 8'h40, l: 8'd0, sum: 8'h00, inj: -1, rsta: -1};
        vecs[2] = '{s: 8'hFE, d: 8'h02, l: 8'd4, sum: 8'hFE, inj: -1, rsta: -1};
        vecs[3] = '{s: 8'h20, d: 8'h21, l: 8'd3, sum: 8'h60, inj: -1, rsta: -1};
        vecs[4] = '{s: 8'h10, d: 8'h80, l: 8'd4, sum: 8'h46, inj: 2, rsta: -1};
        vecs[5] = '{s: 8'h10, d: 8'h80, l: 8'd5, sum: 8'h00, inj: -1, rsta: 5};
        rst = 1'b1; start = 1'b0; load = 1'b0;
        src_base = 8'h00; dst_base = 8'h00; length = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, done, mem_w, mem_r}, 0);
        chk("reset_bus", {mem_adr, mem_datain}, 0);
        chk("reset_checksum", checksum, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            preload();
            run($sformatf("vec%0d", i), vecs[i]);
        end
        preload();
        run("after_rst", vecs[0]);
        for (int i = 0; i < 3; i++) chk("post_match", {mem[8'h80 + i]}, {8'(8'h10 + i)});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus initiator for the 8-bit data memory (adr/datain/w/r/dataout interface).
- On a start pulse it copies a block of bytes from a source base address to a destination base address, one read cycle then one write cycle per byte.
- It also accumulates an 8-bit modulo-256 checksum of the bytes it copies.
- Sits between control logic and the data memory; it is the only driver of the memory port while busy.

Parameters:
- ADDR_W, 8: memory address width; also the width of the length and index registers.
- DATA_W, 8: memory data width; also the width of the checksum.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- src_base  input  ADDR_W  source block base address; latched on accepted start.
- dst_base  input  ADDR_W  destination block base address; latched on accepted start.
- length  input  ADDR_W  number of bytes to copy; latched on accepted start; 0 = no-op.
- busy  output  1  high in READ and WRITE states.
- done  output  1  one-cycle pulse in DONE state.
- checksum  output  DATA_W  sum of copied bytes mod 2^DATA_W; holds until next accepted start.
- mem_adr  output  ADDR_W  memory address.
- mem_datain  output  DATA_W  write data to memory.
- mem_w  output  1  memory write enable; memory writes on the rising edge while high.
- mem_r  output  1  memory read enable; memory data is valid combinationally in the same cycle.
- mem_dataout  input  DATA_W  read data from memory.

Behaviour:
- States: IDLE, READ, WRITE, DONE.
- State is registered. mem_* outputs, busy and done are decoded combinationally from state and registers.
- Reset (rst=1 at edge): state=IDLE, idx=0, buffer=0, checksum=0, latched operands=0.
  - While in IDLE: busy=0, done=0, mem_w=0, mem_r=0, mem_adr=0, mem_datain=0.
- IDLE: if start=1 at an edge, latch src_base, dst_base and length, clear idx and checksum, then:
  - go to READ if length!=0;
  - go to DONE if length==0 (no memory access).
- READ: mem_r=1, mem_w=0, mem_adr=src+idx (mod 2^ADDR_W).
  - At the edge: buffer<=mem_dataout, checksum<=checksum+mem_dataout (mod 2^DATA_W), go to WRITE.
- WRITE: mem_w=1, mem_r=0, mem_adr=dst+idx (mod 2^ADDR_W), mem_datain=buffer.
  - At the edge: idx<=idx+1.
  - If idx+1==length go to DONE, else go to READ.
- DONE: done=1, busy=0, mem_r=mem_w=0. Next edge goes to IDLE.
- mem_r and mem_w are never high in the same cycle. Outside READ/WRITE, mem_adr and mem_datain are 0.
- Latency:
  - start accepted at edge N: first READ cycle is N+1.
  - length=L>0: done is high in cycle N+1+2L.
  - length=0: done is high in cycle N+1.
  - A new start is accepted no earlier than the cycle after DONE.
- start in READ/WRITE/DONE is ignored (no queuing). Changes to src_base/dst_base/length while busy have no effect.
- Address wrap: src+idx and dst+idx wrap modulo 2^ADDR_W, e.g. src=0xFE, len=4 reads 0xFE, 0xFF, 0x00, 0x01.
- Overlap: the copy is strictly ascending, read-then-write per byte. With overlapping blocks and dst>src the source is overwritten before it is read; the result is defined by that order (pattern replication). It is not corrected.
- length is ADDR_W wide, so the maximum copy is 2^ADDR_W-1 bytes.
- rst mid-operation: next state is IDLE with all outputs at reset values. No further memory writes are issued, and no done pulse is produced for the aborted copy.
- rst and start in the same cycle: rst wins and start is dropped.

Test Plan:
- Memory preloaded MEM[i]=i; start with src=0x10, dst=0x80, len=4 -> MEM[0x80..0x83]=0x10..0x13. Addresses seen are 10,80,11,81,12,82,13,83. done pulses exactly 8 cycles after the first READ. checksum=0x46.
- len=0, src=0x00, dst=0x40 -> done one cycle after start, mem_r and mem_w never high, checksum=0x00, memory unchanged.
- Wrap: src=0xFE, dst=0x02, len=4 -> MEM[0x02..0x05]=0xFE, 0xFF, 0x00, 0x01. checksum=0xFE.
- Overlap forward: MEM[i]=i, src=0x20, dst=0x21, len=3 -> MEM[0x21..0x23] all =0x20. checksum=0x60.
- start pulsed again during busy with different operands -> ignored; the original copy completes unchanged and exactly one done pulse is seen.
- rst asserted in the 3rd WRITE of a len=5 copy -> only the first 2 destination bytes are written. busy=done=mem_w=0 from the next cycle, and a subsequent start runs normally.
